// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer with imem/dmem handshakes
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  OpCode,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        pc_we,
  output logic [1:0]  PCSrc,
  output logic [1:0]  RegDst,
  output logic        ExtSel,
  output logic        BSrc,
  output logic [1:0]  WBSrc,
  output logic        retire,
  output logic        trap,
  output logic        halted,
  output logic [31:0] instret,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;
  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_JR = 6'h07, OP_HALT = 6'h3F;
  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] instret_q, instret_d;
  logic        act, legal;
  // Static fields come only from the latched opcode, and only once the instruction is past DECODE
  assign act    = state_q inside {S_EXEC, S_MEM, S_WB};
  assign legal  = OpCode inside {OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_JR};
  assign ExtSel = act && (op_q inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE});
  assign BSrc   = act && (op_q inside {OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW});
  assign RegDst = !act ? 2'b00 : op_q == OP_R ? 2'b01 : op_q == OP_JAL ? 2'b10 : 2'b00;
  assign WBSrc  = !act ? 2'b00 : op_q == OP_LW ? 2'b01 : op_q == OP_JAL ? 2'b10 : 2'b00;
  assign retire  = pc_we;
  assign trap    = state_q == S_TRAP;
  assign halted  = state_q == S_HALT;
  assign instret = instret_q;
  assign state   = state_q;
  // Next-state and per-state strobes; HALT and TRAP fall to the defaults and hold
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    pc_we    = 1'b0;
    PCSrc    = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
        state_d  = imem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        op_d    = OpCode;
        state_d = OpCode == OP_HALT ? S_HALT : legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (op_q)
          OP_BEQ, OP_BNE: begin
            pc_we   = 1'b1;
            PCSrc   = ((op_q == OP_BEQ) == zero) ? 2'b01 : 2'b00;
            state_d = S_FETCH;
          end
          OP_J, OP_JAL: begin
            pc_we    = 1'b1;
            PCSrc    = 2'b11;
            RegWrite = op_q == OP_JAL;
            state_d  = S_FETCH;
          end
          OP_JR: begin
            pc_we   = 1'b1;
            PCSrc   = 2'b10;
            state_d = S_FETCH;
          end
          OP_LW, OP_SW: state_d = S_MEM;
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        MemWrite = op_q == OP_SW;
        pc_we    = dmem_ready && op_q == OP_SW;
        state_d  = !dmem_ready ? S_MEM : op_q == OP_SW ? S_FETCH : S_WB;
      end
      S_WB: begin
        RegWrite = 1'b1;
        pc_we    = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = state_q;
    endcase
  end
  // Retired-instruction counter wraps naturally at 32 bits
  always_comb instret_d = instret_q + {31'b0, pc_we};
  // State, latched opcode and counter with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      op_q      <= 6'h00;
      instret_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      instret_q <= instret_d;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-scenario checks of the multicycle sequencer
module tb_multicycle_control;
  logic        clk, rst, zero, imem_ready, dmem_ready;
  logic [5:0]  OpCode;
  logic        imem_req, ir_we, dmem_req, MemWrite, RegWrite, pc_we, ExtSel, BSrc, retire, trap, halted;
  logic [1:0]  PCSrc, RegDst, WBSrc;
  logic [31:0] instret;
  logic [2:0]  state;
  logic [19:0] obs;
  int n_cmp = 0, n_err = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .zero(zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .pc_we(pc_we), .PCSrc(PCSrc), .RegDst(RegDst), .ExtSel(ExtSel), .BSrc(BSrc), .WBSrc(WBSrc),
    .retire(retire), .trap(trap), .halted(halted), .instret(instret), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {state, imem_req, ir_we, dmem_req, MemWrite, RegWrite, pc_we, retire,
                PCSrc, RegDst, ExtSel, BSrc, WBSrc, trap, halted};

  // strobes order: imem_req, ir_we, dmem_req, MemWrite, RegWrite, pc_we, retire
  function automatic logic [19:0] vec(input logic [2:0] s, input logic [6:0] st, input logic [1:0] pcs,
                                      input logic [1:0] rd, input logic e, input logic b, input logic [1:0] wb);
    return {s, st, pcs, rd, e, b, wb, s == 3'd6, s == 3'd5};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; OpCode = 6'h3E; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== vec(3'd0, 7'b1000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00)) begin
      n_err++; $display("FAIL reset_outputs got %h want %h", obs, vec(3'd0, 7'b1000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00));
    end
    n_cmp++;
    if (instret !== 32'd0) begin n_err++; $display("FAIL reset_instret got %h want 0", instret); end
    step();
  endtask

  task automatic test_addi();
    logic [19:0] exp [4];
    exp = '{vec(3'd0, 7'b1100000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00),
            vec(3'd1, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00),
            vec(3'd2, 7'b0000000, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00),
            vec(3'd4, 7'b0000111, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00)};
    OpCode = 6'h08; imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (obs !== exp[i]) begin n_err++; $display("FAIL addi_c%0d got %h want %h", i, obs, exp[i]); end
      step();
    end
    n_cmp++;
    if (instret !== 32'd1 || state !== 3'd0) begin n_err++; $display("FAIL addi_instret got %h/%0d want 1/0", instret, state); end
  endtask

  task automatic test_lw_wait();
    logic [19:0] exp [8];
    logic [7:0] dr;
    dr = 8'b0100_0000;
    exp = '{vec(3'd0, 7'b1100000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00),
            vec(3'd1, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00),
            vec(3'd2, 7'b0000000, 2'b00, 2'b00, 1'b1, 1'b1, 2'b01),
            vec(3'd3, 7'b0010000, 2'b00, 2'b00, 1'b1, 1'b1, 2'b01),
            vec(3'd3, 7'b0010000, 2'b00, 2'b00, 1'b1, 1'b1, 2'b01),
            vec(3'd3, 7'b0010000, 2'b00, 2'b00, 1'b1, 1'b1, 2'b01),
            vec(3'd3, 7'b0010000, 2'b00, 2'b00, 1'b1, 1'b1, 2'b01),
            vec(3'd4, 7'b0000111, 2'b00, 2'b00, 1'b1, 1'b1, 2'b01)};
    OpCode = 6'h23; imem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dmem_ready = dr[i];
      #1;
      n_cmp++;
      if (obs !== exp[i]) begin n_err++; $display("FAIL lw_c%0d got %h want %h", i, obs, exp[i]); end
      step();
    end
    dmem_ready = 1'b0;
    n_cmp++;
    if (instret !== 32'd2 || state !== 3'd0) begin n_err++; $display("FAIL lw_instret got %h/%0d want 2/0", instret, state); end
  endtask

  task automatic test_branches();
    logic [19:0] exp [10];
    logic [5:0] ops [10];
    logic [9:0] ir;
    ir = 10'b11_1111_1110;
    ops = '{6'h04, 6'h04, 6'h04, 6'h04, 6'h05, 6'h05, 6'h05, 6'h07, 6'h07, 6'h07};
    exp = '{vec(3'd0, 7'b1000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00),
            vec(3'd0, 7'b1100000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00),
            vec(3'd1, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00),
            vec(3'd2, 7'b0000011, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00),
            vec(3'd0, 7'b1100000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00),
            vec(3'd1, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00),
            vec(3'd2, 7'b0000011, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00),
            vec(3'd0, 7'b1100000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00),
            vec(3'd1, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00),
            vec(3'd2, 7'b0000011, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00)};
    zero = 1'b1; dmem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      OpCode = ops[i]; imem_ready = ir[i];
      #1;
      n_cmp++;
      if (obs !== exp[i]) begin n_err++; $display("FAIL branch_c%0d got %h want %h", i, obs, exp[i]); end
      step();
    end
    dmem_ready = 1'b0;
    n_cmp++;
    if (instret !== 32'd5) begin n_err++; $display("FAIL branch_instret got %h want 5", instret); end
  endtask

  task automatic test_jal();
    logic [19:0] exp [3];
    exp = '{vec(3'd0, 7'b1100000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00),
            vec(3'd1, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00),
            vec(3'd2, 7'b0000111, 2'b11, 2'b10, 1'b0, 1'b0, 2'b10)};
    OpCode = 6'h03; imem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (obs !== exp[i]) begin n_err++; $display("FAIL jal_c%0d got %h want %h", i, obs, exp[i]); end
      step();
    end
    n_cmp++;
    if (instret !== 32'd6) begin n_err++; $display("FAIL jal_instret got %h want 6", instret); end
  endtask

  task automatic test_trap();
    int bad = 0;
    OpCode = 6'h3E; imem_ready = 1'b1; zero = 1'b1;
    step();
    step();
    imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (obs !== vec(3'd6, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00)) bad++;
      step();
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL trap_hold got %0d bad cycles want 0 (last %h)", bad, obs); end
    n_cmp++;
    if (instret !== 32'd6) begin n_err++; $display("FAIL trap_instret got %h want 6", instret); end
    imem_ready = 1'b0; dmem_ready = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== vec(3'd0, 7'b1000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00) || instret !== 32'd0) begin
      n_err++; $display("FAIL trap_reset got %h/%h want %h/0", obs, instret, vec(3'd0, 7'b1000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00));
    end
    step();
  endtask

  task automatic test_halt();
    OpCode = 6'h3F; imem_ready = 1'b1;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (obs !== vec(3'd5, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00)) begin
        n_err++; $display("FAIL halt_c%0d got %h want %h", i, obs, vec(3'd5, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00));
      end
      step();
    end
    imem_ready = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_sw_reset();
    logic [19:0] exp [5];
    exp = '{vec(3'd0, 7'b1100000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00),
            vec(3'd1, 7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00),
            vec(3'd2, 7'b0000000, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00),
            vec(3'd3, 7'b0011000, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00),
            vec(3'd3, 7'b0011000, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00)};
    OpCode = 6'h2B; imem_ready = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (obs !== exp[i]) begin n_err++; $display("FAIL sw_c%0d got %h want %h", i, obs, exp[i]); end
      if (i == 4) rst = 1'b0;
      step();
    end
    rst = 1'b1; imem_ready = 1'b0;
    #1;
    n_cmp++;
    if (obs !== vec(3'd0, 7'b1000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00) || instret !== 32'd0) begin
      n_err++; $display("FAIL sw_abort got %h/%h want %h/0", obs, instret, vec(3'd0, 7'b1000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00));
    end
    step();
  endtask

  task automatic test_wrap();
    OpCode = 6'h02; imem_ready = 1'b1; zero = 1'b0;
    step();
    force dut.instret_q = 32'hFFFF_FFFF;
    step();
    release dut.instret_q;
    #1;
    n_cmp++;
    if (obs !== vec(3'd2, 7'b0000011, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00) || instret !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL wrap_exec got %h/%h want %h/ffffffff", obs, instret, vec(3'd2, 7'b0000011, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00));
    end
    step();
    n_cmp++;
    if (instret !== 32'd0 || state !== 3'd0) begin n_err++; $display("FAIL wrap_instret got %h/%0d want 0/0", instret, state); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_branches();
    test_jal();
    test_trap();
    test_halt();
    test_sw_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
